// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit logic unit: eight selectable bitwise gates behind a valid/ready stage.
// Define LOGIC_GATE_UNIT_SWEEP_EN to compile in the exhaustive truth-table self-check sweep.
module logic_gate_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic             sweep_err
);

  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR, OP_XNOR, OP_NOT_A, OP_BUF_A
  } op_e;

  // Shared by the stream datapath and the sweep checker so the sweep exercises the real gates.
  function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0] sel,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] z);
    case (op_e'(sel))
      OP_AND:  gate_fn = x & z;
      OP_OR:   gate_fn = x | z;
      OP_NAND: gate_fn = ~(x & z);
      OP_NOR:  gate_fn = ~(x | z);
      OP_XOR:  gate_fn = x ^ z;
      OP_XNOR: gate_fn = ~(x ^ z);
      OP_NOT_A: gate_fn = ~x;
      default: gate_fn = x;
    endcase
  endfunction

  logic accept;
  assign accept = in_valid && in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= gate_fn(op, a, b);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LOGIC_GATE_UNIT_SWEEP_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sweep_state_e;

  // Reference truth table indexed by {op, a, b}; op 7 (BUF a) in the top nibble.
  localparam logic [31:0] TRUTH_TABLE = {
    4'b1100, 4'b0011, 4'b1001, 4'b0110, 4'b0001, 4'b0111, 4'b1110, 4'b1000
  };

  sweep_state_e     state, state_next;
  logic [4:0]       idx;
  logic             start_ok;
  logic [WIDTH-1:0] sweep_y;

  assign start_ok = sweep_start && !out_valid && !in_valid;
  assign sweep_y  = gate_fn(idx[4:2], {WIDTH{idx[1]}}, {WIDTH{idx[0]}});

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: combinational blocks assign a default first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_ok) state_next = S_RUN;
      S_RUN:   if (idx == 5'd31) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    sweep_busy = (state == S_RUN);
    sweep_done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      sweep_err <= 1'b0;
    end else if (state == S_IDLE && start_ok) begin
      idx       <= '0;
      sweep_err <= 1'b0;
    end else if (state == S_RUN) begin
      idx <= idx + 5'd1;
      if (sweep_y != {WIDTH{TRUTH_TABLE[idx]}}) sweep_err <= 1'b1;
    end
  end

  assign in_ready = (!out_valid || out_ready) && !sweep_busy;
`else
  logic sweep_start_unused;
  assign sweep_start_unused = sweep_start;
  assign sweep_busy = 1'b0;
  assign sweep_done = 1'b0;
  assign sweep_err  = 1'b0;
  assign in_ready   = !out_valid || out_ready;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Scoreboard bench for logic_gate_unit: directed and random stream traffic plus sweep behaviour.
module tb_logic_gate_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, y;
  logic [2:0]   op;
  logic         sweep_start, sweep_busy, sweep_done, sweep_err;

  logic [W-1:0] sb[$];
  logic [W-1:0] last_y;
  bit           mon_en = 1'b0;
  int           n_checks = 0;
  int           n_pass = 0;

  logic_gate_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .sweep_start(sweep_start),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done), .sweep_err(sweep_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: each result bit derived from how many of its inputs are 1.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] z);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      int ones;
      ones = int'(x[i]) + int'(z[i]);
      case (o)
        3'd0: r[i] = (ones == 2);
        3'd1: r[i] = (ones >= 1);
        3'd2: r[i] = (ones < 2);
        3'd3: r[i] = (ones == 0);
        3'd4: r[i] = (ones == 1);
        3'd5: r[i] = (ones != 1);
        3'd6: r[i] = (x[i] == 1'b0);
        default: r[i] = (x[i] == 1'b1);
      endcase
    end
    return r;
  endfunction

  // Monitor: queue occupancy is the expected out_valid; the head is the expected y.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      check("out_valid", out_valid, sb.size() != 0);
      check("in_ready", in_ready, (sb.size() == 0) || out_ready);
      check("sweep_quiet", {sweep_busy, sweep_done}, 2'b00);
      if (sb.size() != 0) begin
        check("y", y, sb[0]);
        if (out_ready) last_y = sb.pop_front();
      end else begin
        check("y_retained", y, last_y);
      end
    end
  end

  task automatic step(input logic v, input logic [2:0] o, input logic [W-1:0] aa,
                      input logic [W-1:0] bb, input logic ordy);
    logic hs;
    in_valid = v; op = o; a = aa; b = bb; out_ready = ordy;
    @(negedge clk);
    hs = in_valid && in_ready;
    @(posedge clk);
    if (hs) sb.push_back(model(o, aa, bb));
    #1;
  endtask

`ifdef LOGIC_GATE_UNIT_SWEEP_EN
  task automatic run_sweep(input int abort_at);
    bit aborted = 1'b0;
    mon_en = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); op = 3'($urandom);
      if (c == abort_at) rst = 1'b1;
      @(negedge clk);
      check("sweep_busy", sweep_busy, 1'b1);
      check("sweep_in_ready", in_ready, 1'b0);
      check("sweep_out_valid", out_valid, 1'b0);
      check("sweep_no_early_done", sweep_done, 1'b0);
      check("sweep_y_untouched", y, last_y);
      @(posedge clk); #1;
      if (c == abort_at) begin
        rst = 1'b0;
        aborted = 1'b1;
        last_y = '0;
        break;
      end
    end
    in_valid = 1'b0;
    if (aborted) begin
      for (int k = 0; k < 36; k++) begin
        @(negedge clk);
        check("abort_busy", sweep_busy, 1'b0);
        check("abort_no_done", sweep_done, 1'b0);
        check("abort_err", sweep_err, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_y", y, '0);
      end
    end else begin
      @(negedge clk);
      check("done_pulse", sweep_done, 1'b1);
      check("done_busy", sweep_busy, 1'b0);
      check("done_err", sweep_err, 1'b0);
      check("done_out_valid", out_valid, 1'b0);
      @(negedge clk);
      check("done_single", sweep_done, 1'b0);
      check("err_held", sweep_err, 1'b0);
    end
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sweep_start = 1'b0;
    a = '0; b = '0; op = '0; last_y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_y", y, '0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_sweep", {sweep_busy, sweep_done, sweep_err}, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // NAND over the four corner patterns, back to back.
    step(1, 3'd2, 8'h00, 8'h00, 1);
    step(1, 3'd2, 8'h00, 8'hFF, 1);
    step(1, 3'd2, 8'hFF, 8'h00, 1);
    step(1, 3'd2, 8'hFF, 8'hFF, 1);
    step(0, 3'd0, 8'h00, 8'h00, 1);

    // XOR held under backpressure, then drained.
    step(1, 3'd4, 8'hA5, 8'h3C, 0);
    repeat (3) step(0, 3'd0, 8'h00, 8'h00, 0);
    step(0, 3'd0, 8'h00, 8'h00, 1);

    // Full pipe replaced without a bubble.
    step(1, 3'd0, 8'h5A, 8'hF0, 1);
    step(1, 3'd6, 8'h0F, 8'h77, 1);
    step(0, 3'd0, 8'h00, 8'h00, 1);

    // Sweep request while a result is pending must be ignored.
    step(1, 3'd1, 8'h12, 8'h40, 0);
    sweep_start = 1'b1;
    step(0, 3'd0, 8'h00, 8'h00, 0);
    sweep_start = 1'b0;
    repeat (3) step(0, 3'd0, 8'h00, 8'h00, 0);
    step(0, 3'd0, 8'h00, 8'h00, 1);
    step(0, 3'd0, 8'h00, 8'h00, 1);

`ifdef LOGIC_GATE_UNIT_SWEEP_EN
    run_sweep(0);
    run_sweep(10);
    run_sweep(0);
`else
    sweep_start = 1'b1;
    step(0, 3'd0, 8'h00, 8'h00, 1);
    sweep_start = 1'b0;
    for (int k = 0; k < 35; k++) begin
      step(0, 3'd0, 8'h00, 8'h00, 1);
      check("no_sweep_err", sweep_err, 1'b0);
    end
`endif

    for (int i = 0; i < 400; i++)
      step($urandom_range(9, 0) < 7, 3'($urandom), W'($urandom), W'($urandom),
           $urandom_range(9, 0) < 6);

    repeat (3) step(0, 3'd0, 8'h00, 8'h00, 1);
    check("scoreboard_empty", sb.size(), 0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
